rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8_pkg.sv | 29 ++
 rtl/rr_arbiter8_prio_enc8.sv | 29 ++
 rtl/rr_arbiter8.sv | 171 +++++++++++++++++
 tb/tb_rr_arbiter8.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter8_pkg
// Shared definitions for the eight-way round-robin arbiter:
//   N_REQ   - number of requesters (8)
//   IDX_W   - width of an encoded requester index (3)
//   state_t - arbiter state, IDLE (no owner) or GRANT (owner latched)
//   rotr8   - rotate an 8-bit vector right so that bit `sh` lands on bit 0
// ---------------------------------------------------------------------------
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Bit j of the result is v[(j + sh) mod 8], so the requester at the
    // pointer becomes bit 0 and the lowest set bit is the first requester
    // at or after the pointer.
    function automatic logic [N_REQ-1:0] rotr8(input logic [N_REQ-1:0] v,
                                               input logic [IDX_W-1:0] sh);
        logic [2*N_REQ-1:0] w_dbl;
        w_dbl = {v, v} >> sh;
        return w_dbl[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter8_prio_enc8.sv
// ---------------------------------------------------------------------------
// prio_enc8
// Combinational 8-to-3 priority encoder, lowest index wins.
// Ports:
//   i_req   [7:0] input vector
//   o_idx   [2:0] index of the lowest set bit (0 when i_req == 0)
//   o_valid       high when any bit of i_req is set
// ---------------------------------------------------------------------------
module prio_enc8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan from the top down so the last (lowest) set bit overwrites.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_idx   = IDX_W'(k);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
// Eight-way round-robin arbiter. With no owner it grants the first
// requester at or after a rotating pointer and holds that grant until the
// owner drops its request; the pointer then moves just past the old owner.
// All outputs are registered from the next state/owner, so there is no
// combinational path from req to the grant outputs.
//
// Optional feature macro: RR_ARBITER8_TIMEOUT_EN
//   defined   - a hold counter revokes a grant after MAX_HOLD cycles and
//               pulses timeout for one cycle
//   undefined - grants are held indefinitely, timeout is tied low
//
// Parameters:
//   MAX_HOLD      maximum consecutive grant cycles per owner (2..255)
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   req     [7:0] request vector, bit k is requester k
//   gnt     [7:0] one-hot grant, zero when no owner
//   gnt_idx [2:0] binary index of the owner, 0 when gnt_valid is low
//   gnt_valid     high while a grant is held
//   timeout       one-cycle pulse when a grant is forcibly revoked
// ---------------------------------------------------------------------------
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_next;
    logic [IDX_W-1:0] r_own;
    logic [IDX_W-1:0] w_own_next;
    logic             w_timeout_next;

    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic             r_timeout;

    logic [N_REQ-1:0] w_gnt_next;
    logic [IDX_W-1:0] w_gnt_idx_next;
    logic             w_gnt_valid_next;

    logic [N_REQ-1:0] w_rot_req;
    logic [IDX_W-1:0] w_enc_idx;
    logic             w_enc_valid;
    logic [IDX_W-1:0] w_sel;

`ifdef RR_ARBITER8_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    logic [7:0] r_hold;
    logic [7:0] w_hold_next;
`endif

    // Selection core: rotate so the pointer is bit 0, pick the lowest set
    // bit, then undo the rotation by adding the pointer back (mod 8).
    assign w_rot_req = rotr8(req, r_ptr);

    prio_enc8 u_prio_enc8 (
        .i_req   (w_rot_req),
        .o_idx   (w_enc_idx),
        .o_valid (w_enc_valid)
    );

    assign w_sel = w_enc_idx + r_ptr;

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_own_next     = r_own;
        w_ptr_next     = r_ptr;
        w_timeout_next = 1'b0;
`ifdef RR_ARBITER8_TIMEOUT_EN
        w_hold_next    = r_hold;
`endif
        case (r_state)
            IDLE: begin
`ifdef RR_ARBITER8_TIMEOUT_EN
                w_hold_next = '0;
`endif
                if (w_enc_valid) begin
                    w_state_next = GRANT;
                    w_own_next   = w_sel;
`ifdef RR_ARBITER8_TIMEOUT_EN
                    // The first cycle of gnt_valid is already cycle one.
                    w_hold_next  = 8'd1;
`endif
                end
            end
            GRANT: begin
                // A voluntary release wins over an expiry on the same cycle.
                if (!req[r_own]) begin
                    w_state_next = IDLE;
                    w_ptr_next   = r_own + IDX_W'(1);
`ifdef RR_ARBITER8_TIMEOUT_EN
                    w_hold_next  = '0;
                end else if (r_hold == HOLD_LIMIT) begin
                    w_state_next   = IDLE;
                    w_ptr_next     = r_own + IDX_W'(1);
                    w_timeout_next = 1'b1;
                    w_hold_next    = '0;
                end else begin
                    w_hold_next = r_hold + 8'd1;
`endif
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output images of the next state, registered below.
    assign w_gnt_valid_next = (w_state_next == GRANT);
    assign w_gnt_idx_next   = w_gnt_valid_next ? w_own_next : '0;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign w_gnt_next[gi] = w_gnt_valid_next && (w_own_next == IDX_W'(gi));
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_own       <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_own       <= w_own_next;
            r_gnt       <= w_gnt_next;
            r_gnt_idx   <= w_gnt_idx_next;
            r_gnt_valid <= w_gnt_valid_next;
            r_timeout   <= w_timeout_next;
        end
    end

`ifdef RR_ARBITER8_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold_next;
        end
    end
`endif

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8
// Directed and random stimulus for rr_arbiter8, checked every cycle against
// a behavioural round-robin model (owner as an integer, pointer as an
// integer, priority found by scanning (ptr + k) mod 8).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_arbiter8;

    localparam int TB_MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_valid = 1'b0;
    int m_own   = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge of the arbitration rules, applied to the sampled inputs.
    task automatic model_edge(input bit r, input logic [7:0] q);
        bit found;
        m_to = 1'b0;
        if (r) begin
            m_valid = 1'b0; m_own = 0; m_ptr = 0; m_held = 0;
        end else if (!m_valid) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found && q[(m_ptr + k) % 8]) begin
                    found   = 1'b1;
                    m_own   = (m_ptr + k) % 8;
                    m_valid = 1'b1;
                    m_held  = 1;
                end
            end
        end else if (!q[m_own]) begin
            m_valid = 1'b0; m_ptr = (m_own + 1) % 8; m_held = 0;
        end
`ifdef RR_ARBITER8_TIMEOUT_EN
        else if (m_held >= TB_MAX_HOLD) begin
            m_valid = 1'b0; m_ptr = (m_own + 1) % 8; m_held = 0; m_to = 1'b1;
        end
`endif
        else begin
            m_held++;
        end
    endtask

    // Apply inputs, clock once, compare every output with the model.
    task automatic step(input bit r, input logic [7:0] q);
        logic [7:0] exp_gnt;
        logic [2:0] enc;
        rst = r;
        req = q;
        @(posedge clk);
        model_edge(r, q);
        #1;
        exp_gnt = m_valid ? (8'h01 << m_own) : 8'h00;
        enc = 3'd0;
        for (int k = 0; k < 8; k++) if (gnt[k]) enc = 3'(k);
        check("gnt",       gnt,                exp_gnt);
        check("gnt_idx",   {5'd0, gnt_idx},    m_valid ? 8'(m_own) : 8'd0);
        check("gnt_valid", {7'd0, gnt_valid},  {7'd0, m_valid});
        check("timeout",   {7'd0, timeout},    {7'd0, m_to});
        check("onehot",    {7'd0, ($countones(gnt) <= 1)}, 8'd1);
        check("idx_enc",   {5'd0, gnt_idx},    {5'd0, enc});
        check("valid_nz",  {7'd0, gnt_valid},  {7'd0, (gnt != 8'h00)});
        $display("step rst=%0d req=%h gnt=%h idx=%0d valid=%0d to=%0d",
                 r, q, gnt, gnt_idx, gnt_valid, timeout);
    endtask

    logic [7:0] rnd_req;

    initial begin
        // Reset with every requester asserted: nothing may be granted.
        step(1'b1, 8'hFF);
        step(1'b1, 8'hFF);
        check("rst_gnt", gnt, 8'h00);
        check("rst_to",  {7'd0, timeout}, 8'd0);
        step(1'b0, 8'hFF);
        check("first_gnt", gnt, 8'h01);

        // Rotation: each owner drops for one cycle, grants walk 1..7,0.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'hFF & ~(8'h01 << i));
            check("rot_idle", gnt, 8'h00);
            step(1'b0, 8'hFF);
            check("rot_next", {5'd0, gnt_idx}, 8'((i + 1) % 8));
        end
        // Release owner 0; ptr=1. Move ptr to 6 by granting/releasing 5.
        step(1'b0, 8'h00);
        step(1'b0, 8'h20);
        check("own5", gnt, 8'h20);
        step(1'b0, 8'h00);
        step(1'b0, 8'h41);
        check("wrap6", gnt, 8'h40);
        step(1'b0, 8'h01);
        check("wrap_rel", gnt, 8'h00);
        step(1'b0, 8'h01);
        check("wrap0", gnt, 8'h01);
        step(1'b0, 8'h00);

        // Lock: owner 3 keeps its request while everyone else also asks.
        step(1'b0, 8'h08);
        check("lock_start", gnt, 8'h08);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'hFF);
`ifndef RR_ARBITER8_TIMEOUT_EN
            check("lock_hold", gnt, 8'h08);
`endif
        end
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        // Mid-grant reset, then ptr=0 so 8'h21 picks requester 0.
        step(1'b0, 8'h20);
        step(1'b0, 8'h20);
        check("pre_rst", gnt, 8'h20);
        step(1'b1, 8'h20);
        check("mid_rst", gnt, 8'h00);
        step(1'b0, 8'h21);
        check("post_rst", gnt, 8'h01);

`ifdef RR_ARBITER8_TIMEOUT_EN
        // Timeout: requester 2 held forever, revoked after TB_MAX_HOLD cycles.
        step(1'b1, 8'h00);
        for (int i = 0; i < TB_MAX_HOLD; i++) begin
            step(1'b0, 8'h04);
            check("to_hold", gnt, 8'h04);
        end
        step(1'b0, 8'h04);
        check("to_drop", gnt, 8'h00);
        check("to_pulse", {7'd0, timeout}, 8'd1);
        step(1'b0, 8'h0C);
        check("to_ptr3", gnt, 8'h08);
        check("to_clear", {7'd0, timeout}, 8'd0);
`endif

        // Random streams: requests mostly held, occasional toggles and resets.
        step(1'b1, 8'h00);
        rnd_req = 8'h00;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) rnd_req[b] = ~rnd_req[b];
            end
            step(($urandom_range(0, 63) == 0), rnd_req);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
